lcd_seq: RTL and testbench
==========================

LCD_SEQ -- requirements
Module: lcd_seq

Interface
REQ-001 Parameter INIT_WAIT, default 750000: power-on wait in clk cycles before the first init nibble (15 ms at 50 MHz).
REQ-002 Parameter NIB_HOLD, default 12: number of cycles lcd_e is held high per nibble.
REQ-003 Parameter NIB_GAP, default 50: idle cycles between the high and low nibble of one byte.
REQ-004 Parameter CMD_WAIT, default 2000: post-byte wait for data and ordinary commands.
REQ-005 Parameter CLR_WAIT, default 82000: post-byte wait for clear/home commands (rs=0, byte 0x01 or 0x02).
REQ-006 clk  in  1  system clock, all state on rising edge.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 req_valid  in  1  requester has a byte to send.
REQ-009 req_ready  out  1  controller accepts a byte this cycle.
REQ-010 req_rs  in  1  register select: 0 command, 1 data.
REQ-011 req_data  in  8  byte to write.
REQ-012 lcd_e  out  1  LCD enable strobe.
REQ-013 lcd_rs  out  1  LCD register select.
REQ-014 lcd_rw  out  1  LCD read/write, constant 0.
REQ-015 sf_e  out  1  StrataFlash/LCD bus select, constant 1 (LCD access).
REQ-016 lcd_d  out  4  LCD data nibble {d,c,b,a}.
REQ-017 init_done  out  1  power-on init sequence complete.
REQ-018 busy  out  1  high whenever the state is not IDLE.

Function
REQ-019 States SHALL be: PWR_WAIT, INIT_SETUP, INIT_PULSE, INIT_WAIT_S, IDLE, HI_SETUP, HI_PULSE, GAP, LO_SETUP, LO_PULSE, POST_WAIT.
REQ-020 After reset release, the block SHALL wait INIT_WAIT cycles, then send the 12-nibble init ROM with rs=0: 3,3,3,2,2,8,0,6,0,C,0,1.
REQ-021 Each init nibble SHALL be followed by CMD_WAIT cycles, except the final nibble (clear), which SHALL be followed by CLR_WAIT cycles; init_done SHALL then rise and the state SHALL become IDLE.
REQ-022 req_ready SHALL equal (state==IDLE && init_done), and a transfer SHALL occur on any cycle where req_valid && req_ready.
REQ-023 On acceptance at cycle N, req_rs and req_data SHALL be latched; later changes to the inputs SHALL have no effect until the next acceptance.
REQ-024 The nibble protocol SHALL be: lcd_rs and lcd_d valid from N+1 (setup, lcd_e=0); lcd_e high from N+2 for exactly NIB_HOLD cycles; the high nibble [7:4] SHALL be sent first.
REQ-025 After the high-nibble pulse, lcd_e SHALL be low for NIB_GAP cycles, followed by one setup cycle and the low-nibble [3:0] pulse of NIB_HOLD cycles.
REQ-026 After the low nibble, the block SHALL wait in POST_WAIT for CLR_WAIT cycles if rs=0 and the byte is 0x01/0x02, otherwise CMD_WAIT cycles, then return to IDLE.
REQ-027 lcd_d and lcd_rs SHALL remain stable throughout each setup+pulse window and SHALL change only while lcd_e=0.
REQ-028 The wait counter SHALL be 20 bits wide and load (value-1), expiring at 0; all parameters SHALL be in the range 1..2^20-1.
REQ-029 req_valid during init SHALL NOT be accepted; the request SHALL be serviced once init_done is asserted and the state is IDLE.
REQ-030 Back-to-back requests: req_ready SHALL reassert in the first IDLE cycle after POST_WAIT expires; no request SHALL ever be dropped or duplicated.

Reset
REQ-031 While rst_n=0: state=PWR_WAIT, lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_d=0, sf_e=1, req_ready=0, init_done=0, busy=1, counter=INIT_WAIT-1.
REQ-032 Reset asserted mid-transfer SHALL force lcd_e low asynchronously, abort the byte without a later resend, and restart the full init sequence.

Structure
REQ-033 Package lcd_pkg SHALL hold the state enum, the 12-entry init nibble ROM, and the constants CMD_CLEAR=0x01 and CMD_HOME=0x02.
REQ-034 One sub-module, lcd_timer, SHALL implement the loadable 20-bit down-counter with a load input and a zero flag.

Verification (bench params INIT_WAIT=20, NIB_HOLD=2, NIB_GAP=3, CMD_WAIT=5, CLR_WAIT=10)
REQ-035 Release reset -> after 20 cycles, 12 lcd_e pulses of 2 cycles carrying 3,3,3,2,2,8,0,6,0,C,0,1 with rs=0; init_done rises 10 cycles after the last pulse; req_ready=0 throughout.
REQ-036 Accept rs=1, data=0x41 -> lcd_d=4 then 1 with rs=1, each lcd_e high exactly 2 cycles with a 3-cycle gap; req_ready returns 5 cycles after the second pulse.
REQ-037 Accept rs=0, data=0x01 -> post wait is 10 cycles (not 5); data 0x01 with rs=1 -> post wait is 5 cycles.
REQ-038 Hold req_valid high with data changing every cycle -> exactly the values present at acceptance cycles appear on lcd_d, one byte per handshake.
REQ-039 Pull rst_n low during the low-nibble pulse -> lcd_e=0 in the same cycle with no clock edge; after release, the init sequence restarts from nibble 3.
REQ-040 Assert req_valid (0x30, rs=1) at cycle 5 after reset -> not accepted until the first cycle of init_done=1, then sent as nibbles 3,0.

Source files
------------

// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared types, init nibble ROM and command constants for lcd_seq
package lcd_pkg;

    typedef enum logic [3:0] {
        PWR_WAIT,
        INIT_SETUP,
        INIT_PULSE,
        INIT_WAIT_S,
        IDLE,
        HI_SETUP,
        HI_PULSE,
        GAP,
        LO_SETUP,
        LO_PULSE,
        POST_WAIT
    } lcd_state_t;

    localparam int         WAIT_W    = 20;
    localparam int         INIT_LEN  = 12;
    localparam logic [3:0] INIT_LAST = 4'(INIT_LEN - 1);
    localparam logic [7:0] CMD_CLEAR = 8'h01;
    localparam logic [7:0] CMD_HOME  = 8'h02;

    // Power-on nibble sequence: three 8-bit wake-ups, switch to 4-bit mode,
    // function set, entry mode, display on, clear.
    function automatic logic [3:0] init_nibble(input logic [3:0] idx);
        logic [3:0] nib;
        case (idx)
            4'd0:    nib = 4'h3;
            4'd1:    nib = 4'h3;
            4'd2:    nib = 4'h3;
            4'd3:    nib = 4'h2;
            4'd4:    nib = 4'h2;
            4'd5:    nib = 4'h8;
            4'd6:    nib = 4'h0;
            4'd7:    nib = 4'h6;
            4'd8:    nib = 4'h0;
            4'd9:    nib = 4'hC;
            4'd10:   nib = 4'h0;
            4'd11:   nib = 4'h1;
            default: nib = 4'h0;
        endcase
        return nib;
    endfunction

    // Clear and home need the long execution wait on the panel.
    function automatic logic is_slow_cmd(input logic rs, input logic [7:0] b);
        return !rs && (b == CMD_CLEAR || b == CMD_HOME);
    endfunction

endpackage

// File: rtl/lcd_timer.sv
// rtl/lcd_timer.sv - loadable 20-bit down-counter with zero flag
// Ports: clk, rst_n (async active-low), load/load_val (reload), zero (count==0).
module lcd_timer
    import lcd_pkg::*;
#(
    parameter logic [WAIT_W-1:0] RST_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [WAIT_W-1:0] load_val,
    output logic              zero
);

    logic [WAIT_W-1:0] count;

    // Saturates at zero so a state that ignores the flag never wraps it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= RST_VAL;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/lcd_seq.sv
// rtl/lcd_seq.sv - 4-bit character LCD init and byte write sequencer
// Ports: clk, rst_n (async active-low); req_valid/req_ready/req_rs/req_data byte
// request handshake; lcd_e/lcd_rs/lcd_rw/lcd_d panel bus; sf_e bus select;
// init_done after power-on sequence; busy whenever not IDLE.
module lcd_seq
    import lcd_pkg::*;
#(
    parameter int unsigned INIT_WAIT = 750000,
    parameter int unsigned NIB_HOLD  = 12,
    parameter int unsigned NIB_GAP   = 50,
    parameter int unsigned CMD_WAIT  = 2000,
    parameter int unsigned CLR_WAIT  = 82000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rs,
    input  logic [7:0] req_data,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       sf_e,
    output logic [3:0] lcd_d,
    output logic       init_done,
    output logic       busy
);

    localparam logic [WAIT_W-1:0] INIT_LD = WAIT_W'(INIT_WAIT - 1);
    localparam logic [WAIT_W-1:0] HOLD_LD = WAIT_W'(NIB_HOLD - 1);
    localparam logic [WAIT_W-1:0] GAP_LD  = WAIT_W'(NIB_GAP - 1);
    localparam logic [WAIT_W-1:0] CMD_LD  = WAIT_W'(CMD_WAIT - 1);
    localparam logic [WAIT_W-1:0] CLR_LD  = WAIT_W'(CLR_WAIT - 1);

    lcd_state_t        state;
    logic [3:0]        idx;
    logic [7:0]        byte_q;
    logic              rs_q;
    logic              tmr_load;
    logic [WAIT_W-1:0] tmr_val;
    logic              tmr_zero;

    lcd_timer #(.RST_VAL(INIT_LD)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    // The timer is reloaded on the same edge the FSM enters a timed state,
    // so every timed state lasts exactly (reload value + 1) cycles.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state)
            INIT_SETUP, HI_SETUP, LO_SETUP: begin
                tmr_load = 1'b1;
                tmr_val  = HOLD_LD;
            end
            INIT_PULSE: begin
                tmr_load = tmr_zero;
                tmr_val  = (idx == INIT_LAST) ? CLR_LD : CMD_LD;
            end
            HI_PULSE: begin
                tmr_load = tmr_zero;
                tmr_val  = GAP_LD;
            end
            LO_PULSE: begin
                tmr_load = tmr_zero;
                tmr_val  = is_slow_cmd(rs_q, byte_q) ? CLR_LD : CMD_LD;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= PWR_WAIT;
            idx       <= '0;
            byte_q    <= '0;
            rs_q      <= 1'b0;
            lcd_e     <= 1'b0;
            lcd_rs    <= 1'b0;
            lcd_d     <= '0;
            init_done <= 1'b0;
        end else begin
            case (state)
                PWR_WAIT: if (tmr_zero) begin
                    lcd_rs <= 1'b0;
                    lcd_d  <= init_nibble(idx);
                    state  <= INIT_SETUP;
                end
                INIT_SETUP: begin
                    lcd_e <= 1'b1;
                    state <= INIT_PULSE;
                end
                INIT_PULSE: if (tmr_zero) begin
                    lcd_e <= 1'b0;
                    state <= INIT_WAIT_S;
                end
                INIT_WAIT_S: if (tmr_zero) begin
                    if (idx == INIT_LAST) begin
                        init_done <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        idx   <= idx + 4'd1;
                        lcd_d <= init_nibble(idx + 4'd1);
                        state <= INIT_SETUP;
                    end
                end
                IDLE: if (req_valid && init_done) begin
                    // Latch the request; the inputs are ignored until the next handshake.
                    rs_q   <= req_rs;
                    byte_q <= req_data;
                    lcd_rs <= req_rs;
                    lcd_d  <= req_data[7:4];
                    state  <= HI_SETUP;
                end
                HI_SETUP: begin
                    lcd_e <= 1'b1;
                    state <= HI_PULSE;
                end
                HI_PULSE: if (tmr_zero) begin
                    lcd_e <= 1'b0;
                    state <= GAP;
                end
                GAP: if (tmr_zero) begin
                    lcd_d <= byte_q[3:0];
                    state <= LO_SETUP;
                end
                LO_SETUP: begin
                    lcd_e <= 1'b1;
                    state <= LO_PULSE;
                end
                LO_PULSE: if (tmr_zero) begin
                    lcd_e <= 1'b0;
                    state <= POST_WAIT;
                end
                POST_WAIT: if (tmr_zero) begin
                    state <= IDLE;
                end
                default: state <= PWR_WAIT;
            endcase
        end
    end

    assign req_ready = (state == IDLE) && init_done;
    assign busy      = (state != IDLE);
    assign lcd_rw    = 1'b0;
    assign sf_e      = 1'b1;

endmodule

// File: tb/tb_lcd_seq.sv
// tb/tb_lcd_seq.sv - directed self-checking bench for lcd_seq
module tb_lcd_seq;

    localparam int INIT_WAIT = 20;
    localparam int NIB_HOLD  = 2;
    localparam int NIB_GAP   = 3;
    localparam int CMD_WAIT  = 5;
    localparam int CLR_WAIT  = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_rs = 1'b0;
    logic [7:0] req_data = 8'h00;
    logic       lcd_e, lcd_rs, lcd_rw, sf_e, init_done, busy;
    logic [3:0] lcd_d;

    lcd_seq #(
        .INIT_WAIT (INIT_WAIT),
        .NIB_HOLD  (NIB_HOLD),
        .NIB_GAP   (NIB_GAP),
        .CMD_WAIT  (CMD_WAIT),
        .CLR_WAIT  (CLR_WAIT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_rs    (req_rs),
        .req_data  (req_data),
        .lcd_e     (lcd_e),
        .lcd_rs    (lcd_rs),
        .lcd_rw    (lcd_rw),
        .sf_e      (sf_e),
        .lcd_d     (lcd_d),
        .init_done (init_done),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         start;
        int         width;
        logic [3:0] d;
        logic       rs;
        bit         stable;
    } pulse_t;

    pulse_t pulses[$];
    pulse_t cur;
    logic   e_prev = 1'b0;

    // Records every lcd_e high window with its nibble and whether the bus held still.
    always @(negedge clk) begin
        if (lcd_e && !e_prev) begin
            cur.start  = cyc;
            cur.width  = 1;
            cur.d      = lcd_d;
            cur.rs     = lcd_rs;
            cur.stable = 1'b1;
        end else if (lcd_e) begin
            cur.width = cur.width + 1;
            if (lcd_d != cur.d || lcd_rs != cur.rs) cur.stable = 1'b0;
        end else if (e_prev) begin
            pulses.push_back(cur);
        end
        e_prev = lcd_e;
    end

    typedef struct {
        logic       rs;
        logic [7:0] data;
        logic [3:0] hi;
        logic [3:0] lo;
        int         post;
    } vec_t;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [3:0] rom [12];
    vec_t vecs [7];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_ready(output int at, input int limit);
        at = -1;
        for (int k = 0; k < limit; k++) begin
            @(negedge clk);
            if (req_ready) begin
                at = cyc;
                break;
            end
        end
    endtask

    // Waits out the power-on sequence after a release at cycle rel and checks it.
    task automatic run_init(input int rel, input string tag);
        int  done_at = -1;
        bit  rdy_early = 1'b0;
        int  period = NIB_HOLD + CMD_WAIT + 1;
        int  first  = rel + INIT_WAIT + 1;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (req_ready && !init_done) rdy_early = 1'b1;
            if (init_done) begin
                done_at = cyc;
                break;
            end
        end
        check({tag, "_ready_low_during_init"}, int'(rdy_early), 0);
        check({tag, "_pulse_count"}, pulses.size(), 12);
        for (int i = 0; i < 12 && i < pulses.size(); i++) begin
            check($sformatf("%s_nib%0d_d", tag, i), int'(pulses[i].d), int'(rom[i]));
            check($sformatf("%s_nib%0d_rs", tag, i), int'(pulses[i].rs), 0);
            check($sformatf("%s_nib%0d_width", tag, i), pulses[i].width, NIB_HOLD);
            check($sformatf("%s_nib%0d_start", tag, i), pulses[i].start, first + i * period);
            check($sformatf("%s_nib%0d_stable", tag, i), int'(pulses[i].stable), 1);
        end
        check({tag, "_init_done_cycle"}, done_at,
              first + 11 * period + NIB_HOLD + CLR_WAIT);
    endtask

    task automatic send_byte(input vec_t v, input string tag);
        int acc, rdy;
        wait_ready(acc, 300);
        check({tag, "_accept_seen"}, int'(acc >= 0), 1);
        pulses.delete();
        req_valid = 1'b1;
        req_rs    = v.rs;
        req_data  = v.data;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_rs    = ~v.rs;
        req_data  = ~v.data;
        wait_ready(rdy, 300);
        check({tag, "_pulse_count"}, pulses.size(), 2);
        if (pulses.size() >= 2) begin
            check({tag, "_hi_d"}, int'(pulses[0].d), int'(v.hi));
            check({tag, "_lo_d"}, int'(pulses[1].d), int'(v.lo));
            check({tag, "_hi_rs"}, int'(pulses[0].rs), int'(v.rs));
            check({tag, "_lo_rs"}, int'(pulses[1].rs), int'(v.rs));
            check({tag, "_hi_width"}, pulses[0].width, NIB_HOLD);
            check({tag, "_lo_width"}, pulses[1].width, NIB_HOLD);
            check({tag, "_stable"}, int'(pulses[0].stable && pulses[1].stable), 1);
            check({tag, "_hi_start"}, pulses[0].start, acc + 2);
            check({tag, "_lo_start"}, pulses[1].start, acc + 2 + NIB_HOLD + NIB_GAP + 1);
            check({tag, "_post_wait"}, rdy - (pulses[1].start + pulses[1].width), v.post);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int rel, acc, rdy, first_done, n_acc;
        logic [7:0] exp_q[$];

        rom = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8, 4'h0, 4'h6, 4'h0, 4'hC, 4'h0, 4'h1};
        vecs[0] = '{1'b1, 8'h41, 4'h4, 4'h1, CMD_WAIT};
        vecs[1] = '{1'b0, 8'h01, 4'h0, 4'h1, CLR_WAIT};
        vecs[2] = '{1'b1, 8'h01, 4'h0, 4'h1, CMD_WAIT};
        vecs[3] = '{1'b0, 8'h02, 4'h0, 4'h2, CLR_WAIT};
        vecs[4] = '{1'b0, 8'h03, 4'h0, 4'h3, CMD_WAIT};
        vecs[5] = '{1'b1, 8'hA5, 4'hA, 4'h5, CMD_WAIT};
        vecs[6] = '{1'b1, 8'h02, 4'h0, 4'h2, CMD_WAIT};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_lcd_e", int'(lcd_e), 0);
        check("rst_lcd_rs", int'(lcd_rs), 0);
        check("rst_lcd_rw", int'(lcd_rw), 0);
        check("rst_lcd_d", int'(lcd_d), 0);
        check("rst_sf_e", int'(sf_e), 1);
        check("rst_req_ready", int'(req_ready), 0);
        check("rst_init_done", int'(init_done), 0);
        check("rst_busy", int'(busy), 1);

        // Power-on init
        @(negedge clk);
        rst_n = 1'b1;
        rel = cyc;
        #1 pulses.delete();
        run_init(rel, "init");
        check("idle_busy", int'(busy), 0);

        // Single bytes, including clear/home wait selection
        for (int i = 0; i < 7; i++) send_byte(vecs[i], $sformatf("vec%0d", i));

        // Back-to-back with data changing every cycle
        pulses.delete();
        exp_q.delete();
        n_acc = 0;
        for (int k = 0; k < 400 && n_acc < 3; k++) begin
            @(negedge clk);
            req_rs    = 1'b1;
            req_data  = 8'(k * 37 + 5);
            req_valid = 1'b1;
            if (req_ready) begin
                exp_q.push_back(req_data);
                n_acc++;
            end
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        wait_ready(rdy, 300);
        check("b2b_accepts", n_acc, 3);
        check("b2b_pulse_count", pulses.size(), 6);
        for (int i = 0; i < 3 && 2 * i + 1 < pulses.size() && i < exp_q.size(); i++) begin
            check($sformatf("b2b%0d_hi", i), int'(pulses[2*i].d), int'(exp_q[i][7:4]));
            check($sformatf("b2b%0d_lo", i), int'(pulses[2*i+1].d), int'(exp_q[i][3:0]));
            check($sformatf("b2b%0d_rs", i), int'(pulses[2*i].rs && pulses[2*i+1].rs), 1);
        end

        // Reset during the low-nibble pulse
        wait_ready(acc, 300);
        pulses.delete();
        req_valid = 1'b1;
        req_rs    = 1'b1;
        req_data  = 8'h5A;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (pulses.size() == 1 && lcd_e) break;
        end
        check("midrst_in_lo_pulse", int'(lcd_e), 1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_lcd_e_async", int'(lcd_e), 0);
        check("midrst_init_done", int'(init_done), 0);
        check("midrst_busy", int'(busy), 1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        rel = cyc;
        #1 pulses.delete();
        run_init(rel, "reinit");
        repeat (30) @(negedge clk);
        check("reinit_no_resend", pulses.size(), 12);

        // Request held from early init is serviced on the first init_done cycle
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        rel = cyc;
        #1 pulses.delete();
        acc = -1;
        first_done = -1;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (cyc == rel + 5) begin
                req_valid = 1'b1;
                req_rs    = 1'b1;
                req_data  = 8'h30;
            end
            if (req_ready && !req_valid) check("early_ready_before_valid", 1, 0);
            if (init_done && first_done < 0) first_done = cyc;
            if (req_ready && req_valid) begin
                acc = cyc;
                break;
            end
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        wait_ready(rdy, 300);
        check("early_accept_seen", int'(acc >= 0), 1);
        check("early_accept_at_done", acc, first_done);
        check("early_pulse_count", pulses.size(), 14);
        if (pulses.size() >= 14) begin
            check("early_hi_d", int'(pulses[12].d), 3);
            check("early_lo_d", int'(pulses[13].d), 0);
            check("early_rs", int'(pulses[12].rs && pulses[13].rs), 1);
            check("early_hi_start", pulses[12].start, acc + 2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
